// File: rtl/axi_param_pkg.sv
// Shared AXI4 parameters, channel field types, encodings and the write responder FSM state.
package AXI_param_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ADDR_W = 32;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [7:0]            axi_len_t;
  typedef logic [2:0]            axi_size_t;
  typedef logic [1:0]            axi_burst_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [1:0]            axi_resp_t;

  localparam axi_size_t  AXI_SIZE_4B     = 3'd2;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;
  localparam axi_resp_t  AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t  AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t  AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {StIdle, StData, StResp} wr_state_e;

endpackage

// File: rtl/axi_wr_mem.sv
// Byte-enabled word RAM: one write port, one registered read port (read-before-write).
module axi_wr_mem
  import AXI_param_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  axi_data_t                  wdata_i,
  input  logic [AXI_DATA_W/8-1:0]    wstrb_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output axi_data_t                  rdata_o
);

  axi_data_t mem [DEPTH];
  axi_data_t rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < AXI_DATA_W / 8; b++) begin
        if (wstrb_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_write_responder.sv
// AXI4 write subordinate: one outstanding burst, stores beats into axi_wr_mem, one B per burst.
module axi_write_responder
  import AXI_param_pkg::*;
#(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ID_W-1:0]           awid,
  input  axi_addr_t                 awaddr,
  input  axi_len_t                  awlen,
  input  axi_size_t                 awsize,
  input  axi_burst_t                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  axi_data_t                 wdata,
  input  logic [AXI_DATA_W/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_W-1:0]           bid,
  output axi_resp_t                 bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output axi_data_t                 rd_data
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned OFF = $clog2(AXI_DATA_W / 8);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [AW-1:0]     addr_q, addr_d;
  axi_len_t          len_q, len_d, beat_q, beat_d;
  axi_burst_t        burst_q, burst_d;
  axi_resp_t         resp_q, resp_d, aw_resp;
  logic              err_q, err_d;
  logic              awready_q, wready_q, bvalid_q;
  logic              mem_we, last_beat;
  logic [AXI_ADDR_W:0] aw_word, aw_end;

  // Range check in one extra bit so start_word+len cannot wrap.
  assign aw_word = {1'b0, awaddr} >> OFF;
  assign aw_end  = aw_word + {{(AXI_ADDR_W + 1 - 8){1'b0}}, awlen};

  always_comb begin
    aw_resp = AXI_RESP_OKAY;
    if ((awburst == AXI_BURST_INCR  && aw_end  >= (AXI_ADDR_W + 1)'(DEPTH)) ||
        (awburst == AXI_BURST_FIXED && aw_word >= (AXI_ADDR_W + 1)'(DEPTH))) begin
      aw_resp = AXI_RESP_DECERR;
    end else if (awsize != AXI_SIZE_4B || awburst[1]) begin
      aw_resp = AXI_RESP_SLVERR;
    end
  end

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    resp_d  = resp_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (awvalid && awready_q) begin
          id_d    = awid;
          addr_d  = aw_word[AW-1:0];
          len_d   = awlen;
          burst_d = awburst;
          beat_d  = '0;
          resp_d  = aw_resp;
          err_d   = (aw_resp != AXI_RESP_OKAY);
          state_d = StData;
        end
      end
      StData: begin
        if (wvalid && wready_q) begin
          mem_we = !err_q;
          if ((wlast != last_beat) && (resp_q != AXI_RESP_DECERR)) resp_d = AXI_RESP_SLVERR;
          if (burst_q == AXI_BURST_INCR) addr_d = addr_q + AW'(1);
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StResp;
        end
      end
      StResp: begin
        if (bvalid_q && bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      burst_q   <= AXI_BURST_FIXED;
      resp_q    <= AXI_RESP_OKAY;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      burst_q   <= burst_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      awready_q <= (state_d == StIdle);
      wready_q  <= (state_d == StData);
      bvalid_q  <= (state_d == StResp);
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = id_q;
  assign bresp   = resp_q;

  axi_wr_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule
